// File: rtl/mem_stage_lsu_if.sv
// Data-memory valid/ready bus between the MEM-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one word access per MEM-stage op on a valid/ready
// data bus, stalling the pipeline until the access completes, faults or times out.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWriteM,
  input  logic            ResultSrcM,
  input  logic [31:0]     ALU_ResultM,
  input  logic [31:0]     WriteDataM,
  input  logic            stall_ext,
  mem_stage_lsu_if.master bus,
  output logic            mem_stall,
  output logic [31:0]     ReadDataM,
  output logic            load_valid,
  output logic            misalign_err,
  output logic            bus_err
);
  localparam int unsigned      XLEN     = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic              req_we_q, req_we_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              load_valid_q, load_valid_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic op_m;
  logic timeout;

  assign op_m    = MemWriteM | ResultSrcM;
  // The last permitted bus cycle wins over any handshake or response seen in it.
  assign timeout = (cnt_q == CNT_LAST);

  assign mem_stall     = op_m & (state_q != DONE);
  assign bus.req_valid = req_valid_q;
  assign bus.req_we    = req_we_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign ReadDataM     = rdata_q;
  assign load_valid    = load_valid_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = bus_err_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      rdata_q      <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      rdata_q      <= rdata_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    rdata_d      = rdata_q;
    load_valid_d = load_valid_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (op_m) begin
          if (ALU_ResultM[1:0] == 2'b00) begin
            req_valid_d = 1'b1;
            req_we_d    = MemWriteM;
            req_addr_d  = ALU_ResultM;
            req_wdata_d = WriteDataM;
            cnt_d       = '0;
            state_d     = REQ;
          end else begin
            rdata_d      = '0;
            misalign_d   = 1'b1;
            bus_err_d    = 1'b0;
            load_valid_d = ~MemWriteM;
            state_d      = DONE;
          end
        end
      end

      REQ: begin
        if (timeout) begin
          req_valid_d  = 1'b0;
          rdata_d      = '0;
          bus_err_d    = 1'b1;
          load_valid_d = ~req_we_q;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.req_ready) begin
            req_valid_d = 1'b0;
            state_d     = RSP;
          end
        end
      end

      RSP: begin
        if (timeout) begin
          rdata_d      = '0;
          bus_err_d    = 1'b1;
          load_valid_d = ~req_we_q;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.rsp_valid) begin
            rdata_d      = (req_we_q | bus.rsp_err) ? '0 : bus.rsp_rdata;
            bus_err_d    = bus.rsp_err;
            load_valid_d = ~req_we_q;
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        // Held by another stall source: keep the result so the op is not reissued.
        if (!stall_ext) begin
          load_valid_d = 1'b0;
          misalign_d   = 1'b0;
          bus_err_d    = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: per-op expectations derived from handshake timing,
// checked every cycle by one compare process, plus literal pins on key results.
module tb_mem_stage_lsu;
  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        ResultSrcM = 1'b0;
  logic [31:0] ALU_ResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        stall_ext = 1'b0;
  logic        mem_stall;
  logic [31:0] ReadDataM;
  logic        load_valid;
  logic        misalign_err;
  logic        bus_err;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemWriteM    (MemWriteM),
    .ResultSrcM   (ResultSrcM),
    .ALU_ResultM  (ALU_ResultM),
    .WriteDataM   (WriteDataM),
    .stall_ext    (stall_ext),
    .bus          (bus.master),
    .mem_stall    (mem_stall),
    .ReadDataM    (ReadDataM),
    .load_valid   (load_valid),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdly;       // cycles req_ready stays low in REQ
    int          sdly;       // cycles in RSP before rsp_valid; <0 = never
    logic        err;
    logic [31:0] rdata;
    int          hold;       // stall_ext cycles while in DONE
    int          gap;        // idle cycles after the op
    logic        stray;      // rsp_valid pulse in first idle cycle
    int          lit_stall;  // hand-computed stall cycles, <0 = none
    logic        lit_rd_en;
    logic [31:0] lit_rdata;  // hand-computed ReadDataM in DONE
  } op_t;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model expectations for the current cycle
  logic        e_stall, e_req_valid, e_we, e_done, e_lv, e_mis, e_berr;
  logic [31:0] e_addr, e_wdata, e_rdata;

  int          obs_stall, obs_hs;
  logic [31:0] obs_rdata;

  op_t ops[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic rd, input logic [31:0] addr,
                                input logic [31:0] wdata, input int rdly, input int sdly,
                                input logic err, input logic [31:0] rdata, input int hold,
                                input int gap, input logic stray, input int lit_stall,
                                input logic lit_rd_en, input logic [31:0] lit_rdata);
    op_t o;
    o.we = we; o.rd = rd; o.addr = addr; o.wdata = wdata;
    o.rdly = rdly; o.sdly = sdly; o.err = err; o.rdata = rdata;
    o.hold = hold; o.gap = gap; o.stray = stray;
    o.lit_stall = lit_stall; o.lit_rd_en = lit_rd_en; o.lit_rdata = lit_rdata;
    return o;
  endfunction

  always @(posedge clk)
    if (bus.req_valid && bus.req_ready) obs_hs++;

  // Single compare process against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("req_valid", 32'(bus.req_valid), 32'(e_req_valid));
      if (e_req_valid) begin
        chk("req_addr", bus.req_addr, e_addr);
        chk("req_wdata", bus.req_wdata, e_wdata);
        chk("req_we", 32'(bus.req_we), 32'(e_we));
      end
      chk("load_valid", 32'(load_valid), 32'(e_done & e_lv));
      chk("misalign_err", 32'(misalign_err), 32'(e_done & e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_done & e_berr));
      if (e_done) begin
        chk("ReadDataM", ReadDataM, e_rdata);
        obs_rdata = ReadDataM;
      end
      if (mem_stall) obs_stall++;
    end
  end

  task automatic run_op(input op_t o);
    logic mis, tmo;
    int r, s, l, last, exp_hs;
    mis  = (o.addr[1:0] != 2'b00);
    r    = o.rdly + 1;
    s    = (o.sdly < 0) ? 1000 : o.sdly + 1;
    tmo  = !mis && (r + s >= int'(T));
    l    = mis ? 1 : (tmo ? 1 + int'(T) : 1 + r + s);
    last = l + o.hold;
    exp_hs = (!mis && r <= int'(T)) ? 1 : 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        obs_stall = 0;
        obs_hs    = 0;
      end
      MemWriteM     = o.we;
      ResultSrcM    = o.rd;
      ALU_ResultM   = o.addr;
      WriteDataM    = o.wdata;
      bus.req_ready = !mis && k >= r;
      bus.rsp_valid = !mis && o.sdly >= 0 && k == r + s;
      bus.rsp_rdata = (k == r + s) ? o.rdata : 32'($urandom);
      bus.rsp_err   = o.err;
      stall_ext     = (k >= l) && (k < l + o.hold);
      e_stall       = k < l;
      e_req_valid   = !mis && k >= 1 && k <= r && k <= int'(T);
      e_addr        = o.addr;
      e_wdata       = o.wdata;
      e_we          = o.we;
      e_done        = k >= l;
      e_lv          = !o.we;
      e_mis         = mis;
      e_berr        = !mis && (tmo || o.err);
      e_rdata       = (o.we || mis || tmo || o.err) ? 32'h0 : o.rdata;
      chk_en        = 1'b1;
    end
    for (int g = 0; g < o.gap; g++) begin
      @(posedge clk); #1;
      MemWriteM     = 1'b0;
      ResultSrcM    = 1'b0;
      ALU_ResultM   = 32'($urandom);
      bus.req_ready = 1'b0;
      bus.rsp_valid = o.stray && g == 0;
      bus.rsp_rdata = 32'h7777_7777;
      bus.rsp_err   = 1'b0;
      stall_ext     = 1'b0;
      e_stall       = 1'b0;
      e_req_valid   = 1'b0;
      e_done        = 1'b0;
    end
    @(negedge clk); #1;
    bus.rsp_valid = 1'b0;
    chk("op_stall_cycles", 32'(obs_stall), 32'(l));
    chk("op_handshakes", 32'(obs_hs), 32'(exp_hs));
    if (o.lit_stall >= 0) chk("op_stall_literal", 32'(obs_stall), 32'(o.lit_stall));
    if (o.lit_rd_en) chk("op_rdata_literal", obs_rdata, o.lit_rdata);
  endtask

  initial begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    obs_stall = 0;
    obs_hs    = 0;
    obs_rdata = '0;
    {e_stall, e_req_valid, e_we, e_done, e_lv, e_mis, e_berr} = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;

    #3;
    chk("rst_req_valid", 32'(bus.req_valid), 32'h0);
    chk("rst_req_we", 32'(bus.req_we), 32'h0);
    chk("rst_req_addr", bus.req_addr, 32'h0);
    chk("rst_req_wdata", bus.req_wdata, 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_flags", 32'({load_valid, misalign_err, bus_err}), 32'h0);
    chk("rst_mem_stall", 32'(mem_stall), 32'h0);
    #19 rst = 1'b1;

    //                 we    rd    addr          wdata         rdly sdly err   rdata         hold gap stray lit  en    lit_rdata
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0100, 32'h0,        0,   0,   1'b0, 32'hDEAD_BEEF, 0,  1,  1'b0, 3,   1'b1, 32'hDEAD_BEEF));
    ops.push_back(mk_op(1'b1, 1'b0, 32'h0000_0204, 32'h55AA_55AA, 4,   0,   1'b0, 32'hFFFF_FFFF, 0,  1,  1'b0, 7,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0102, 32'h0,        0,   0,   1'b0, 32'h1111_1111, 0,  1,  1'b0, 1,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0300, 32'h0,        0,   -1,  1'b0, 32'h2222_2222, 0,  2,  1'b1, 9,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0400, 32'h0,        0,   1,   1'b1, 32'h1234_5678, 0,  1,  1'b0, 4,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0500, 32'h0,        0,   0,   1'b0, 32'hCAFE_F00D, 2,  1,  1'b0, 3,   1'b1, 32'hCAFE_F00D));
    ops.push_back(mk_op(1'b1, 1'b1, 32'h0000_0207, 32'h3333_3333, 0,   0,   1'b0, 32'h4444_4444, 0,  1,  1'b0, 1,   1'b0, 32'h0));
    ops.push_back(mk_op(1'b1, 1'b1, 32'h0000_0600, 32'hA5A5_0F0F, 1,   2,   1'b0, 32'h5555_5555, 0,  0,  1'b0, 6,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0604, 32'h0,        0,   0,   1'b0, 32'h0BAD_C0DE, 0,  1,  1'b0, 3,   1'b1, 32'h0BAD_C0DE));
    ops.push_back(mk_op(1'b1, 1'b0, 32'h0000_0608, 32'h6666_6666, 30,  0,   1'b0, 32'h0,        0,  1,  1'b0, 9,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_060C, 32'h0,        0,   5,   1'b0, 32'h1357_9BDF, 0,  1,  1'b0, 8,   1'b1, 32'h1357_9BDF));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0610, 32'h0,        0,   6,   1'b0, 32'h8888_8888, 0,  1,  1'b0, 9,   1'b1, 32'h0));
    ops.push_back(mk_op(1'b0, 1'b1, 32'h0000_0614, 32'h0,        2,   0,   1'b0, 32'h2468_ACE0, 1,  1,  1'b1, 5,   1'b1, 32'h2468_ACE0));

    foreach (ops[i]) run_op(ops[i]);

    // Reset while the request is waiting for req_ready.
    chk_en = 1'b0;
    @(posedge clk); #1;
    MemWriteM = 1'b0; ResultSrcM = 1'b1; ALU_ResultM = 32'h0000_0700; WriteDataM = 32'h0;
    bus.req_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req_valid", 32'(bus.req_valid), 32'h1);
    chk("pre_rst_req_addr", bus.req_addr, 32'h0000_0700);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(bus.req_valid), 32'h0);
    chk("mid_rst_req_addr", bus.req_addr, 32'h0);
    chk("mid_rst_flags", 32'({load_valid, misalign_err, bus_err}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ResultSrcM = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    chk("post_rst_req_valid", 32'(bus.req_valid), 32'h0);
    chk("post_rst_mem_stall", 32'(mem_stall), 32'h0);
    chk("post_rst_flags", 32'({load_valid, misalign_err, bus_err}), 32'h0);

    run_op(mk_op(1'b0, 1'b1, 32'h0000_0704, 32'h0, 0, 0, 1'b0, 32'hFEED_FACE, 0, 2, 1'b0, 3, 1'b1, 32'hFEED_FACE));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
